// File: rtl/du_word_serializer.sv
// du_word_serializer: splits a DWORD-wide word into BYTE-wide characters and
// hands them one at a time to a UART transmitter using a start/done handshake.
module du_word_serializer #(
    parameter int DWORD     = 32,
    parameter int BYTE      = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_word_valid,
    input  logic [DWORD-1:0] i_word,
    output logic             o_word_ready,
    output logic [BYTE-1:0]  o_tx_data,
    output logic             o_tx_start,
    input  logic             i_tx_done,
    output logic             o_busy,
    output logic             o_done
);
    localparam int NBYTES = DWORD / BYTE;
    localparam int IW     = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic [DWORD-1:0] sr;
    logic             last;

    assign last = idx == IW'(NBYTES - 1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // The outgoing byte always sits at the output end of the shift register,
    // so it stays put through WAIT and after DONE without a separate latch.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            idx <= '0;
            sr  <= '0;
        end else if (state == IDLE && i_word_valid) begin
            idx <= '0;
            sr  <= i_word;
        end else if (state == WAIT && i_tx_done && !last) begin
            idx <= idx + 1'b1;
            sr  <= LSB_FIRST != 0 ? sr >> BYTE : sr << BYTE;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_word_valid ? START : IDLE;
            START:   state_nx = WAIT;
            WAIT:    state_nx = i_tx_done ? (last ? DONE : START) : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_word_ready = state == IDLE;
        o_busy       = state != IDLE;
        o_tx_start   = state == START;
        o_done       = state == DONE;
        o_tx_data    = LSB_FIRST != 0 ? sr[BYTE-1:0] : sr[DWORD-1 -: BYTE];
    end
endmodule

// File: doc/du_word_serializer.md
DU_WORD_SERIALIZER -- requirements
Module: du_word_serializer

Interface
REQ-001 The module SHALL have parameter DWORD, default 32, meaning word width in bits (multiple of BYTE).
REQ-002 The module SHALL have parameter BYTE, default 8, meaning UART character width.
REQ-003 The module SHALL have parameter LSB_FIRST, default 1, meaning byte order: 1 = bits [7:0] sent first, 0 = bits [DWORD-1:DWORD-8] first.
REQ-004 The module SHALL have port i_clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port i_reset, input, 1, meaning reset; asynchronous, active-high.
REQ-006 The module SHALL have port i_word_valid, input, 1, meaning a word to transmit is present on i_word.
REQ-007 The module SHALL have port i_word, input, DWORD, meaning word to transmit (PC, register or data-memory value).
REQ-008 The module SHALL have port o_word_ready, output, 1, meaning a word can be accepted this cycle.
REQ-009 The module SHALL have port o_tx_data, output, BYTE, meaning byte presented to the UART transmitter.
REQ-010 The module SHALL have port o_tx_start, output, 1, meaning a one-cycle request to the UART to send o_tx_data.
REQ-011 The module SHALL have port i_tx_done, input, 1, meaning the UART's one-cycle tick that the current byte has finished.
REQ-012 The module SHALL have port o_busy, output, 1, meaning a word is being serialized.
REQ-013 The module SHALL have port o_done, output, 1, meaning a one-cycle pulse after the last byte of a word completes.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT and DONE; NBYTES = DWORD/BYTE; byte index counter width SHALL be clog2(NBYTES), minimum 1 bit.
REQ-015 In IDLE: o_word_ready=1 and o_busy=0; when i_word_valid=1 at a rising edge, the block SHALL capture i_word into a shift register, clear the index and go to START.
REQ-016 In START: o_tx_start=1 for exactly one cycle, o_tx_data=current byte, then unconditionally go to WAIT.
REQ-017 In WAIT: o_tx_start=0 and o_tx_data held stable; on i_tx_done=1: if index=NBYTES-1 go to DONE, else increment index, shift the next byte out and go to START.
REQ-018 In DONE: o_done=1 for exactly one cycle, then go to IDLE.
REQ-019 o_busy SHALL be 1 in START, WAIT and DONE; o_word_ready SHALL be 1 only in IDLE.
REQ-020 Latency: accept edge k gives o_tx_start high in cycle k+1; i_tx_done at edge m gives the next o_tx_start in cycle m+1; the final i_tx_done at edge m gives o_done in cycle m+1 and o_word_ready in cycle m+2.
REQ-021 i_tx_done SHALL be ignored in IDLE, START and DONE.
REQ-022 i_word_valid SHALL be ignored outside IDLE; a word presented while busy is not captured, and the source must hold valid until ready.
REQ-023 Changes on i_word after capture SHALL NOT affect bytes being sent.
REQ-024 After DONE, o_tx_data SHALL keep the last byte sent until the next START.
REQ-025 Back-to-back words: valid held high through DONE SHALL be accepted on the first IDLE cycle, giving minimum 2 cycles from the o_done pulse to the next accept edge.

Reset
REQ-026 i_reset=1 SHALL immediately force IDLE, index=0, shift register=0, o_tx_data=0, o_tx_start=0, o_done=0, o_busy=0 and o_word_ready=1, independent of the clock.
REQ-027 Reset mid-word SHALL abandon the word with no further o_tx_start; i_tx_done arriving after release SHALL be ignored.

Verification
REQ-028 Reset then i_word=0x12345678 for one valid cycle, LSB_FIRST=1, tx_done 5 cycles after each start -> bytes 0x78,0x56,0x34,0x12, exactly 4 start pulses, one o_done.
REQ-029 Same stimulus with LSB_FIRST=0 -> bytes 0x12,0x34,0x56,0x78.
REQ-030 i_word changed to 0xFFFFFFFF during WAIT, and valid pulsed while busy -> original bytes unaffected and no second capture.
REQ-031 Valid held high with 0xAABBCCDD then 0x01020304 -> 8 bytes in order, ready low throughout each word, o_done twice.
REQ-032 i_tx_done asserted in IDLE and in the START cycle -> no state or index change.
REQ-033 i_reset asserted asynchronously during WAIT of byte 2 -> outputs reach reset values before the next edge; next word starts from byte 0.
